// File: rtl/lamp_pkg.sv
// lamp_pkg: shared types and helpers for the lamp fade sequencer.
// Holds the sequencer state encoding, the default PWM resolution and the
// constant functions that size the step prescaler and the hold length.
package lamp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RAMP_UP   = 3'd1,
        ST_HOLD      = 3'd2,
        ST_RAMP_DOWN = 3'd3,
        ST_SWAP      = 3'd4
    } lamp_state_t;

    localparam int C_PWM_BITS_DEF = 32'sd8;

    // Clock cycles per brightness step.
    function automatic int tick_div(input int freq, input int step_ms);
        return (freq / 32'sd1000) * step_ms;
    endfunction

    // Step ticks spent at full brightness; never less than one.
    function automatic int hold_ticks(input int hold_ms, input int step_ms);
        int h;
        h = hold_ms / step_ms;
        if (h < 32'sd1) begin
            return 32'sd1;
        end else begin
            return h;
        end
    endfunction

endpackage

// File: rtl/lamp_pwm.sv
// lamp_pwm: one PWM channel of the lamp fade sequencer.
// A free-running counter is compared against a duty value that is only
// picked up when the counter wraps, so a duty change never cuts a period
// short. All instances reset together and therefore stay phase-aligned.
module lamp_pwm
    import lamp_pkg::*;
#(
    parameter int c_pwm_bits = C_PWM_BITS_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [c_pwm_bits-1:0] i_duty,
    output logic                  o_pwm
);

    localparam logic [c_pwm_bits-1:0] C_CNT_MAX = {c_pwm_bits{1'b1}};

    logic [c_pwm_bits-1:0] r_cnt;
    logic [c_pwm_bits-1:0] r_duty;
    logic                  r_pwm;

    // Period counter, wrap-aligned duty latch and registered compare output.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= {c_pwm_bits{1'b0}};
            r_duty <= {c_pwm_bits{1'b0}};
            r_pwm  <= 1'b0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == C_CNT_MAX) begin
                r_duty <= i_duty;
            end else begin
                r_duty <= r_duty;
            end
            r_pwm <= (r_cnt < r_duty);
        end
    end

    assign o_pwm = r_pwm;

endmodule

// File: rtl/lamp_fade_ctrl.sv
// lamp_fade_ctrl: alternating two-channel LED fade sequencer.
// Ramps the active channel up, holds it at full brightness, ramps it down
// and then hands the fade to the other channel. A stop request finishes the
// current fade-out gracefully and parks in IDLE without swapping channels.
// Optional build macro: LAMP_GAMMA_EN selects a squared duty curve instead
// of the linear level-to-duty mapping; sequencing is identical either way.
module lamp_fade_ctrl
    import lamp_pkg::*;
#(
    parameter int c_freq     = 32'sd12000000,
    parameter int c_pwm_bits = C_PWM_BITS_DEF,
    parameter int c_step_ms  = 32'sd4,
    parameter int c_hold_ms  = 32'sd500
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_stop,
    output logic                  o_led1,
    output logic                  o_led2,
    output logic                  o_busy,
    output logic [c_pwm_bits-1:0] o_level
);

    localparam int C_N  = tick_div(c_freq, c_step_ms);
    localparam int C_CW = (C_N > 32'sd1) ? $clog2(C_N) : 32'sd1;
    localparam int C_H  = hold_ticks(c_hold_ms, c_step_ms);
    localparam int C_HW = $clog2(C_H + 32'sd1);

    localparam logic [C_CW-1:0]       C_TICK_LAST = C_CW'(C_N - 32'sd1);
    localparam logic [C_HW-1:0]       C_HOLD_LAST = C_HW'(C_H - 32'sd1);
    localparam logic [c_pwm_bits-1:0] C_LVL_MAX   = {c_pwm_bits{1'b1}};
    localparam logic [c_pwm_bits-1:0] C_LVL_ZERO  = {c_pwm_bits{1'b0}};

`ifdef LAMP_GAMMA_EN
    // Squared perceptual curve: (level * level) >> c_pwm_bits.
    function automatic logic [c_pwm_bits-1:0] f_gamma(input logic [c_pwm_bits-1:0] lvl);
        logic [2*c_pwm_bits-1:0] sq;
        sq = {{c_pwm_bits{1'b0}}, lvl} * {{c_pwm_bits{1'b0}}, lvl};
        return c_pwm_bits'(sq >> c_pwm_bits);
    endfunction
`endif

    lamp_state_t           r_state;
    lamp_state_t           w_state_nx;
    logic [C_CW-1:0]       r_tick_cnt;
    logic [C_HW-1:0]       r_hold_cnt;
    logic [C_HW-1:0]       w_hold_nx;
    logic [c_pwm_bits-1:0] r_level;
    logic [c_pwm_bits-1:0] w_level_nx;
    logic                  r_stop_pend;
    logic                  w_pend_nx;
    logic                  r_chan;
    logic                  w_chan_nx;
    logic                  r_busy;
    logic                  w_tick;
    logic [c_pwm_bits-1:0] w_lvl_inc;
    logic [c_pwm_bits-1:0] w_lvl_dec;
    logic [c_pwm_bits-1:0] w_duty;
    logic [c_pwm_bits-1:0] w_duty0;
    logic [c_pwm_bits-1:0] w_duty1;

    // Step prescaler: parked at zero while idle so the first tick lands N cycles after start.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tick_cnt <= {C_CW{1'b0}};
        end else if (r_state == ST_IDLE) begin
            r_tick_cnt <= {C_CW{1'b0}};
        end else if (r_tick_cnt == C_TICK_LAST) begin
            r_tick_cnt <= {C_CW{1'b0}};
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    assign w_tick = (r_state != ST_IDLE) && (r_tick_cnt == C_TICK_LAST);

    // Saturating neighbours of the current level.
    always_comb begin
        w_lvl_inc = r_level;
        w_lvl_dec = r_level;
        if (r_level == C_LVL_MAX) begin
            w_lvl_inc = r_level;
        end else begin
            w_lvl_inc = r_level + 1'b1;
        end
        if (r_level == C_LVL_ZERO) begin
            w_lvl_dec = r_level;
        end else begin
            w_lvl_dec = r_level - 1'b1;
        end
    end

    // Sequencer next-state logic; a stop request outranks a coincident tick.
    always_comb begin
        w_state_nx = r_state;
        w_level_nx = r_level;
        w_hold_nx  = r_hold_cnt;
        w_pend_nx  = r_stop_pend;
        w_chan_nx  = r_chan;
        case (r_state)
            ST_IDLE: begin
                w_pend_nx = 1'b0;
                if (i_start && !i_stop) begin
                    w_state_nx = ST_RAMP_UP;
                    w_level_nx = C_LVL_ZERO;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_RAMP_UP: begin
                if (i_stop || r_stop_pend) begin
                    w_pend_nx  = 1'b1;
                    w_state_nx = ST_RAMP_DOWN;
                end else if (w_tick) begin
                    w_level_nx = w_lvl_inc;
                    if (w_lvl_inc == C_LVL_MAX) begin
                        w_state_nx = ST_HOLD;
                        w_hold_nx  = {C_HW{1'b0}};
                    end else begin
                        w_state_nx = ST_RAMP_UP;
                    end
                end else begin
                    w_state_nx = ST_RAMP_UP;
                end
            end
            ST_HOLD: begin
                if (i_stop || r_stop_pend) begin
                    w_pend_nx  = 1'b1;
                    w_state_nx = ST_RAMP_DOWN;
                end else if (w_tick) begin
                    if (r_hold_cnt == C_HOLD_LAST) begin
                        w_state_nx = ST_RAMP_DOWN;
                        w_hold_nx  = {C_HW{1'b0}};
                    end else begin
                        w_state_nx = ST_HOLD;
                        w_hold_nx  = r_hold_cnt + 1'b1;
                    end
                end else begin
                    w_state_nx = ST_HOLD;
                end
            end
            ST_RAMP_DOWN: begin
                w_pend_nx = r_stop_pend | i_stop;
                if (w_tick) begin
                    w_level_nx = w_lvl_dec;
                    if (w_lvl_dec == C_LVL_ZERO) begin
                        if (r_stop_pend || i_stop) begin
                            w_state_nx = ST_IDLE;
                            w_pend_nx  = 1'b0;
                        end else begin
                            w_state_nx = ST_SWAP;
                        end
                    end else begin
                        w_state_nx = ST_RAMP_DOWN;
                    end
                end else begin
                    w_state_nx = ST_RAMP_DOWN;
                end
            end
            ST_SWAP: begin
                w_chan_nx  = ~r_chan;
                w_state_nx = ST_RAMP_UP;
                w_pend_nx  = r_stop_pend | i_stop;
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_level_nx = C_LVL_ZERO;
                w_hold_nx  = {C_HW{1'b0}};
                w_pend_nx  = 1'b0;
            end
        endcase
    end

    // Sequencer state, level, hold count, stop flag, active channel and busy flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_level     <= C_LVL_ZERO;
            r_hold_cnt  <= {C_HW{1'b0}};
            r_stop_pend <= 1'b0;
            r_chan      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_level     <= w_level_nx;
            r_hold_cnt  <= w_hold_nx;
            r_stop_pend <= w_pend_nx;
            r_chan      <= w_chan_nx;
            r_busy      <= (w_state_nx != ST_IDLE);
        end
    end

`ifdef LAMP_GAMMA_EN
    // Perceptual duty from the current level.
    always_comb begin
        w_duty = f_gamma(r_level);
    end
`else
    // Linear duty: the level is the duty.
    always_comb begin
        w_duty = r_level;
    end
`endif

    // Route the duty to the active channel; the idle channel is held dark.
    always_comb begin
        w_duty0 = C_LVL_ZERO;
        w_duty1 = C_LVL_ZERO;
        if (r_chan) begin
            w_duty1 = w_duty;
        end else begin
            w_duty0 = w_duty;
        end
    end

    lamp_pwm #(
        .c_pwm_bits(c_pwm_bits)
    ) u_pwm0 (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_duty (w_duty0),
        .o_pwm  (o_led1)
    );

    lamp_pwm #(
        .c_pwm_bits(c_pwm_bits)
    ) u_pwm1 (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_duty (w_duty1),
        .o_pwm  (o_led2)
    );

    assign o_busy  = r_busy;
    assign o_level = r_level;

endmodule
